// File: rtl/lcd_px_pacer_if.sv
// ---------------------------------------------------------------------------
// lcd_px_pacer_if
//   Bundles the PPU-side inputs and the LCD-driver-side outputs of
//   lcd_px_pacer. The master modport is the PPU/stimulus side and the slave
//   modport is the pacer itself.
//
//   PPU -> pacer : in_disp_on, in_hsync, in_vsync, in_px_out, in_px[1:0]
//   pacer -> LCD : disp_on, hsync, vsync, px_out, px[1:0]
//   status       : level[clog2(DEPTH):0], overflow
//   optional     : drop_count[7:0] when LCD_PX_PACER_STATS_EN is defined
// ---------------------------------------------------------------------------
interface lcd_px_pacer_if #(
    parameter int DEPTH = 16
);
    localparam int LW = $clog2(DEPTH) + 1;

    logic          in_disp_on;
    logic          in_hsync;
    logic          in_vsync;
    logic          in_px_out;
    logic [1:0]    in_px;

    logic          disp_on;
    logic          hsync;
    logic          vsync;
    logic          px_out;
    logic [1:0]    px;
    logic [LW-1:0] level;
    logic          overflow;
`ifdef LCD_PX_PACER_STATS_EN
    logic [7:0]    drop_count;
`endif

    modport master (
        output in_disp_on, in_hsync, in_vsync, in_px_out, in_px,
        input  disp_on, hsync, vsync, px_out, px, level,
`ifdef LCD_PX_PACER_STATS_EN
        input  drop_count,
`endif
        input  overflow
    );

    modport slave (
        input  in_disp_on, in_hsync, in_vsync, in_px_out, in_px,
        output disp_on, hsync, vsync, px_out, px, level,
`ifdef LCD_PX_PACER_STATS_EN
        output drop_count,
`endif
        output overflow
    );
endinterface

// File: rtl/lcd_px_pacer.sv
// ---------------------------------------------------------------------------
// lcd_px_pacer
//   Elastic buffer between the PPU pixel output and the LCD panel driver.
//   Pixels and hsync/vsync events are queued as 4-bit tokens {kind, px} in
//   arrival order and replayed as registered single-cycle strobes. After
//   every emitted pixel the output is held idle for GAP cycles. After the
//   display is enabled nothing is queued until the first vsync, so the
//   driver always starts on a frame boundary.
//
//   Parameters
//     DEPTH  FIFO entries (power of two, 4..64)
//     GAP    idle cycles forced after each pixel strobe (0..15)
//
//   Ports
//     clk    clock
//     reset  synchronous, active-high reset
//     bus    lcd_px_pacer_if.slave (PPU inputs, LCD strobes, level,
//            overflow, and drop_count when enabled)
//
//   Build option
//     LCD_PX_PACER_STATS_EN  adds a saturating 8-bit dropped-token counter
//                            (bus.drop_count).
// ---------------------------------------------------------------------------
module lcd_px_pacer #(
    parameter int DEPTH = 16,
    parameter int GAP   = 1
) (
    input  logic          clk,
    input  logic          reset,
    lcd_px_pacer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    localparam logic [1:0] K_VSYNC = 2'd1;
    localparam logic [1:0] K_HSYNC = 2'd2;
    localparam logic [1:0] K_PIXEL = 2'd3;

    typedef enum logic [1:0] {
        ST_OFF      = 2'd0,
        ST_SYNCWAIT = 2'd1,
        ST_RUN      = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [LW-1:0] wr_cnt_q, wr_cnt_d;
    logic [LW-1:0] rd_cnt_q, rd_cnt_d;
    logic [3:0]    gap_q, gap_d;
    logic          disp_on_q;
    logic          vsync_q, vsync_d;
    logic          hsync_q, hsync_d;
    logic          px_out_q, px_out_d;
    logic [1:0]    px_q, px_d;
    logic          overflow_q, overflow_d;

    logic [3:0]    mem [DEPTH];

    logic [LW-1:0] level;
    logic          empty;
    logic          full;
    logic [3:0]    head;
    logic          pop;
    logic          push_en;
    logic          push_req;
    logic [3:0]    push_tok;
    logic [1:0]    n_in;

`ifdef LCD_PX_PACER_STATS_EN
    logic [7:0]    drop_q, drop_d;
    logic [1:0]    n_drop;

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [1:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {7'b0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction
`endif

    // Counts are one bit wider than the address so a full FIFO is
    // distinguishable from an empty one.
    assign level = wr_cnt_q - rd_cnt_q;
    assign empty = (level == '0);
    assign full  = (level == LW'(DEPTH));
    assign head  = mem[rd_cnt_q[AW-1:0]];
    assign n_in  = {1'b0, bus.in_vsync} + {1'b0, bus.in_hsync} + {1'b0, bus.in_px_out};

    always_comb begin
        state_d    = state_q;
        wr_cnt_d   = wr_cnt_q;
        rd_cnt_d   = rd_cnt_q;
        gap_d      = (gap_q != 4'd0) ? gap_q - 4'd1 : 4'd0;
        vsync_d    = 1'b0;
        hsync_d    = 1'b0;
        px_out_d   = 1'b0;
        px_d       = px_q;
        overflow_d = overflow_q;
        pop        = 1'b0;
        push_en    = 1'b0;
        push_req   = 1'b0;
        push_tok   = 4'd0;
`ifdef LCD_PX_PACER_STATS_EN
        drop_d     = drop_q;
        n_drop     = 2'd0;
`endif

        if (!bus.in_disp_on) begin
            // Display disabled: discard everything, no drain.
            state_d  = ST_OFF;
            wr_cnt_d = '0;
            rd_cnt_d = '0;
            gap_d    = 4'd0;
        end else begin
            case (state_q)
                ST_OFF: begin
                    state_d    = ST_SYNCWAIT;
                    overflow_d = 1'b0;
`ifdef LCD_PX_PACER_STATS_EN
                    drop_d     = 8'd0;
`endif
                end
                default: begin
                    pop = !empty && (gap_q == 4'd0);
                    if (pop) begin
                        rd_cnt_d = rd_cnt_q + LW'(1);
                        case (head[3:2])
                            K_VSYNC: vsync_d = 1'b1;
                            K_HSYNC: hsync_d = 1'b1;
                            K_PIXEL: begin
                                px_out_d = 1'b1;
                                px_d     = head[1:0];
                                gap_d    = 4'(GAP);
                            end
                            default: ;
                        endcase
                    end

                    if (state_q == ST_SYNCWAIT) begin
                        // Only a vsync may open the stream.
                        if (bus.in_vsync) begin
                            push_req = 1'b1;
                            push_tok = {K_VSYNC, 2'b00};
                            state_d  = ST_RUN;
                        end
                    end else begin
                        push_req = (n_in != 2'd0);
                        if (bus.in_vsync)      push_tok = {K_VSYNC, 2'b00};
                        else if (bus.in_hsync) push_tok = {K_HSYNC, 2'b00};
                        else                   push_tok = {K_PIXEL, bus.in_px};
                        if (n_in > 2'd1) begin
                            overflow_d = 1'b1;
`ifdef LCD_PX_PACER_STATS_EN
                            n_drop     = n_in - 2'd1;
`endif
                        end
                    end

                    if (push_req) begin
                        // A same-cycle pop frees the slot the push needs.
                        if (full && !pop) begin
                            overflow_d = 1'b1;
`ifdef LCD_PX_PACER_STATS_EN
                            n_drop     = n_drop + 2'd1;
`endif
                        end else begin
                            push_en  = 1'b1;
                            wr_cnt_d = wr_cnt_q + LW'(1);
                        end
                    end
`ifdef LCD_PX_PACER_STATS_EN
                    if (n_drop != 2'd0) drop_d = sat_add8(drop_q, n_drop);
`endif
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_OFF;
            wr_cnt_q   <= '0;
            rd_cnt_q   <= '0;
            gap_q      <= 4'd0;
            disp_on_q  <= 1'b0;
            vsync_q    <= 1'b0;
            hsync_q    <= 1'b0;
            px_out_q   <= 1'b0;
            px_q       <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_cnt_q   <= wr_cnt_d;
            rd_cnt_q   <= rd_cnt_d;
            gap_q      <= gap_d;
            disp_on_q  <= bus.in_disp_on;
            vsync_q    <= vsync_d;
            hsync_q    <= hsync_d;
            px_out_q   <= px_out_d;
            px_q       <= px_d;
            overflow_q <= overflow_d;
        end
    end

    // Token storage carries no reset; occupancy is tracked by the counts.
    always_ff @(posedge clk) begin
        if (push_en) begin
            mem[wr_cnt_q[AW-1:0]] <= push_tok;
        end
    end

`ifdef LCD_PX_PACER_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) drop_q <= 8'd0;
        else       drop_q <= drop_d;
    end
    assign bus.drop_count = drop_q;
`endif

    assign bus.disp_on  = disp_on_q;
    assign bus.vsync    = vsync_q;
    assign bus.hsync    = hsync_q;
    assign bus.px_out   = px_out_q;
    assign bus.px       = px_q;
    assign bus.level    = level;
    assign bus.overflow = overflow_q;
endmodule
